// File: rtl/helper_axis_pkg.sv
// Shared constants and the LFSR step function for the AXIS test helpers.
package helper_axis_pkg;

    localparam int unsigned LFSR_WIDTH  = 16;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam int unsigned COUNT_WIDTH = 32;

    // One step of a right-shifting Galois LFSR.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        lfsr_next = {1'b0, s[LFSR_WIDTH-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/helper_lfsr16.sv
// Free-running 16-bit Galois LFSR; loads seed on reset (a zero seed becomes 1).
module helper_lfsr16
    import helper_axis_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic [LFSR_WIDTH-1:0] state
);

    logic [LFSR_WIDTH-1:0] r_state;

    // Advance every non-reset cycle so the pattern depends only on cycles since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (seed == '0) ? LFSR_WIDTH'(1) : seed;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/helper_axis_throttle.sv
// Inline AXIS stall injector: 2-entry FIFO with LFSR-driven ready/valid gaps and beat counters.
module helper_axis_throttle
    import helper_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int unsigned IN_STALL   = 0,
    parameter int unsigned OUT_STALL  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    input  logic [DATA_WIDTH-1:0]  input_data,
    output logic                   input_ready,
    output logic                   output_valid,
    output logic [DATA_WIDTH-1:0]  output_data,
    input  logic                   output_ready,
    output logic [COUNT_WIDTH-1:0] in_count,
    output logic [COUNT_WIDTH-1:0] out_count
);

    // Thresholds above 255 would silently truncate in the 8-bit compares below.
    if (IN_STALL > 255) begin : g_bad_in_stall
        $error("IN_STALL must be in 0..255");
    end
    if (OUT_STALL > 255) begin : g_bad_out_stall
        $error("OUT_STALL must be in 0..255");
    end

    localparam logic [7:0] InTh  = IN_STALL[7:0];
    localparam logic [7:0] OutTh = OUT_STALL[7:0];

    logic [LFSR_WIDTH-1:0]  w_lfsr;
    logic                   w_in_stall;
    logic                   w_out_stall;
    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_push;
    logic                   w_pop;

    logic [DATA_WIDTH-1:0]  r_mem [2];
    logic                   r_head;
    logic                   r_tail;
    logic [1:0]             r_occ;
    logic                   r_presenting;
    logic [COUNT_WIDTH-1:0] r_in_count;
    logic [COUNT_WIDTH-1:0] r_out_count;

    helper_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (SEED),
        .state (w_lfsr)
    );

    // Stall decisions and handshakes; out_stall only blocks starting a new beat.
    always_comb begin
        w_in_stall  = w_lfsr[7:0] < InTh;
        w_out_stall = w_lfsr[15:8] < OutTh;
        w_in_ready  = !rst && (r_occ != 2'd2) && !w_in_stall;
        w_out_valid = !rst && (r_occ != 2'd0) && (r_presenting || !w_out_stall);
        w_push      = input_valid && w_in_ready;
        w_pop       = w_out_valid && output_ready;
    end

    // Output drive; data forced to zero while in reset.
    always_comb begin
        input_ready  = w_in_ready;
        output_valid = w_out_valid;
        output_data  = rst ? '0 : r_mem[r_head];
        in_count     = r_in_count;
        out_count    = r_out_count;
    end

    // FIFO storage, pointers, occupancy, presenting flag and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_head       <= 1'b0;
            r_tail       <= 1'b0;
            r_occ        <= 2'd0;
            r_presenting <= 1'b0;
            r_in_count   <= '0;
            r_out_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= input_data;
                r_tail        <= ~r_tail;
                r_in_count    <= r_in_count + 1'b1;
            end
            if (w_pop) begin
                r_head      <= ~r_head;
                r_out_count <= r_out_count + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
            // Once valid is shown it must be held until the handshake.
            r_presenting <= w_out_valid && !output_ready;
        end
    end

endmodule
